// File: rtl/eth_frame_parser_if.sv
// Byte-stream receive input plus parsed header, payload and per-frame status
// outputs of the Ethernet receive parser.
interface eth_frame_parser_if;
    logic [7:0]  rxData;
    logic        rxValid;
    logic [47:0] destMac;
    logic [47:0] srcMac;
    logic [15:0] etherType;
    logic        hdrValid;
    logic [7:0]  payloadData;
    logic        payloadValid;
    logic        payloadLast;
    logic        frameDone;
    logic        crcValid;
    logic        errRunt;
    logic        errGiant;
    logic        errAlign;
    logic [15:0] frameLen;

    modport master (
        output rxData, rxValid,
        input  destMac, srcMac, etherType, hdrValid,
        input  payloadData, payloadValid, payloadLast,
        input  frameDone, crcValid, errRunt, errGiant, errAlign, frameLen
    );

    modport slave (
        input  rxData, rxValid,
        output destMac, srcMac, etherType, hdrValid,
        output payloadData, payloadValid, payloadLast,
        output frameDone, crcValid, errRunt, errGiant, errAlign, frameLen
    );
endinterface

// File: rtl/eth_frame_parser.sv
// Ethernet receive parser: preamble/SFD detection, header extraction, payload
// streaming with optional FCS stripping, CRC-32 check and frame error flags.
module eth_frame_parser #(
    parameter int MIN_FRAME_LEN  = 64,
    parameter int MAX_FRAME_LEN  = 1518,
    parameter bit CHECK_PREAMBLE = 1'b1,
    parameter bit STRIP_FCS      = 1'b1
) (
    input logic               clk_i,
    input logic               rst_ni,
    eth_frame_parser_if.slave bus
);
    localparam int          DLY_DEPTH   = STRIP_FCS ? 5 : 1;
    localparam logic [2:0]  DLY_FULL    = 3'(DLY_DEPTH);
    localparam logic [15:0] MIN_LEN     = 16'(MIN_FRAME_LEN);
    localparam logic [15:0] MAX_LEN     = 16'(MAX_FRAME_LEN);
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    typedef enum logic [2:0] {IDLE, PREAMBLE, DST, SRC, TYPE, PAYLOAD, DROP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  fill_q, fill_d;
    logic [7:0]  dly_q [DLY_DEPTH];
    logic [7:0]  dly_d [DLY_DEPTH];
    logic [31:0] crc_q, crc_d;
    logic [15:0] len_q, len_d;
    logic [47:0] dst_q, dst_d;
    logic [47:0] src_q, src_d;
    logic [15:0] type_q, type_d;
    logic [7:0]  payData_q, payData_d;
    logic        payValid_q, payValid_d;
    logic        payLast_q, payLast_d;
    logic        hdrValid_q, hdrValid_d;
    logic        done_q, done_d;
    logic        crcOk_q, crcOk_d;
    logic        runt_q, runt_d;
    logic        giant_q, giant_d;
    logic        align_q, align_d;

    logic [7:0]  rxData;
    logic        rxValid;
    logic [31:0] crcNext;
    logic [15:0] lenInc;
    logic        startFrame;

    function automatic logic [31:0] crcByte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] r;
        r = crc ^ {24'h0, data};
        for (int b = 0; b < 8; b++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    assign rxData  = bus.rxData;
    assign rxValid = bus.rxValid;
    assign crcNext = crcByte(crc_q, rxData);
    assign lenInc  = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;

    // Status of the previous frame is kept until the next frame really starts:
    // its SFD, its first DST byte, or a preamble byte that is misaligned.
    assign startFrame = rxValid &&
                        (((state_q == IDLE) && (!CHECK_PREAMBLE || (rxData != 8'h55))) ||
                         ((state_q == PREAMBLE) && (rxData != 8'h55)));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fill_d     = fill_q;
        dly_d      = dly_q;
        crc_d      = crc_q;
        len_d      = len_q;
        dst_d      = dst_q;
        src_d      = src_q;
        type_d     = type_q;
        payData_d  = payData_q;
        payValid_d = 1'b0;
        payLast_d  = 1'b0;
        hdrValid_d = 1'b0;
        done_d     = 1'b0;
        crcOk_d    = crcOk_q;
        runt_d     = runt_q;
        giant_d    = giant_q;
        align_d    = align_q;

        if (startFrame) begin
            crcOk_d = 1'b0;
            runt_d  = 1'b0;
            giant_d = 1'b0;
            align_d = 1'b0;
            len_d   = '0;
            crc_d   = CRC_INIT;
            dst_d   = '0;
            src_d   = '0;
            type_d  = '0;
        end

        case (state_q)
            IDLE: begin
                if (rxValid) begin
                    if (CHECK_PREAMBLE) begin
                        if (rxData == 8'h55) begin
                            state_d = PREAMBLE;
                        end else begin
                            state_d = DROP;
                            align_d = 1'b1;
                        end
                    end else begin
                        state_d = DST;
                        cnt_d   = 3'd1;
                        dst_d   = {40'h0, rxData};
                        len_d   = 16'd1;
                        crc_d   = crcByte(CRC_INIT, rxData);
                    end
                end
            end
            PREAMBLE: begin
                if (!rxValid) begin
                    state_d = IDLE;
                end else if (rxData == 8'hD5) begin
                    state_d = DST;
                    cnt_d   = '0;
                end else if (rxData != 8'h55) begin
                    state_d = DROP;
                    align_d = 1'b1;
                end
            end
            DST, SRC, TYPE: begin
                if (!rxValid) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    runt_d  = 1'b1;
                    crcOk_d = 1'b0;
                end else begin
                    crc_d = crcNext;
                    len_d = lenInc;
                    cnt_d = cnt_q + 3'd1;
                    if (state_q == DST) begin
                        dst_d = {dst_q[39:0], rxData};
                        if (cnt_q == 3'd5) begin
                            state_d = SRC;
                            cnt_d   = '0;
                        end
                    end else if (state_q == SRC) begin
                        src_d = {src_q[39:0], rxData};
                        if (cnt_q == 3'd5) begin
                            state_d = TYPE;
                            cnt_d   = '0;
                        end
                    end else begin
                        type_d = {type_q[7:0], rxData};
                        if (cnt_q == 3'd1) begin
                            state_d    = PAYLOAD;
                            cnt_d      = '0;
                            fill_d     = '0;
                            hdrValid_d = 1'b1;
                        end
                    end
                end
            end
            PAYLOAD: begin
                if (!rxValid) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    crcOk_d = (crc_q == CRC_RESIDUE);
                    runt_d  = (len_q < MIN_LEN);
                    if (fill_q == DLY_FULL) begin
                        payValid_d = 1'b1;
                        payLast_d  = 1'b1;
                        payData_d  = dly_q[DLY_DEPTH-1];
                    end
                end else begin
                    crc_d = crcNext;
                    len_d = lenInc;
                    // An oversize frame closes its payload stream with the oldest held byte.
                    if (lenInc > MAX_LEN) begin
                        state_d = DROP;
                        giant_d = 1'b1;
                        if (fill_q == DLY_FULL) begin
                            payValid_d = 1'b1;
                            payLast_d  = 1'b1;
                            payData_d  = dly_q[DLY_DEPTH-1];
                        end
                    end else begin
                        dly_d[0] = rxData;
                        for (int i = 1; i < DLY_DEPTH; i++) begin
                            dly_d[i] = dly_q[i-1];
                        end
                        if (fill_q == DLY_FULL) begin
                            payValid_d = 1'b1;
                            payData_d  = dly_q[DLY_DEPTH-1];
                        end else begin
                            fill_d = fill_q + 3'd1;
                        end
                    end
                end
            end
            DROP: begin
                if (!rxValid) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    crcOk_d = (crc_q == CRC_RESIDUE) && !align_q;
                    runt_d  = (len_q < MIN_LEN);
                    giant_d = giant_q || (len_q > MAX_LEN);
                end else if (!align_q) begin
                    crc_d = crcNext;
                    len_d = lenInc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            fill_q     <= '0;
            for (int i = 0; i < DLY_DEPTH; i++) begin
                dly_q[i] <= '0;
            end
            crc_q      <= CRC_INIT;
            len_q      <= '0;
            dst_q      <= '0;
            src_q      <= '0;
            type_q     <= '0;
            payData_q  <= '0;
            payValid_q <= 1'b0;
            payLast_q  <= 1'b0;
            hdrValid_q <= 1'b0;
            done_q     <= 1'b0;
            crcOk_q    <= 1'b0;
            runt_q     <= 1'b0;
            giant_q    <= 1'b0;
            align_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fill_q     <= fill_d;
            dly_q      <= dly_d;
            crc_q      <= crc_d;
            len_q      <= len_d;
            dst_q      <= dst_d;
            src_q      <= src_d;
            type_q     <= type_d;
            payData_q  <= payData_d;
            payValid_q <= payValid_d;
            payLast_q  <= payLast_d;
            hdrValid_q <= hdrValid_d;
            done_q     <= done_d;
            crcOk_q    <= crcOk_d;
            runt_q     <= runt_d;
            giant_q    <= giant_d;
            align_q    <= align_d;
        end
    end

    assign bus.destMac      = dst_q;
    assign bus.srcMac       = src_q;
    assign bus.etherType    = type_q;
    assign bus.hdrValid     = hdrValid_q;
    assign bus.payloadData  = payData_q;
    assign bus.payloadValid = payValid_q;
    assign bus.payloadLast  = payLast_q;
    assign bus.frameDone    = done_q;
    assign bus.crcValid     = crcOk_q;
    assign bus.errRunt      = runt_q;
    assign bus.errGiant     = giant_q;
    assign bus.errAlign     = align_q;
    assign bus.frameLen     = len_q;
endmodule

// File: tb/tb_eth_frame_parser.sv
// Scoreboard bench for eth_frame_parser: directed frames push expected header,
// payload and status records; a negedge monitor pops and compares them.
module tb_eth_frame_parser;
    typedef struct packed {
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] etype;
    } hdr_t;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } pay_t;

    typedef struct packed {
        logic        crcOk;
        logic        runt;
        logic        giant;
        logic        align;
        logic [15:0] len;
    } stat_t;

    logic clock = 1'b0;
    logic resetN;
    int   checks = 0;
    int   failures = 0;

    hdr_t  hdrQ[$];
    pay_t  payQ[$];
    stat_t statQ[$];
    logic [7:0] frm[$];
    logic [7:0] txBytes[$];

    hdr_t  monHdr;
    pay_t  monPay;
    stat_t monStat;

    always #5 clock = ~clock;

    eth_frame_parser_if bus();

    eth_frame_parser dut (
        .clk_i (clock),
        .rst_ni(resetN),
        .bus   (bus)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    function automatic stat_t mkStat(input logic c, input logic r, input logic g, input logic a, input logic [15:0] len);
        stat_t s;
        s.crcOk = c;
        s.runt  = r;
        s.giant = g;
        s.align = a;
        s.len   = len;
        return s;
    endfunction

    // Generates the FCS for the bytes currently in frm, bit-serially, LSB first.
    function automatic logic [31:0] fcsOf();
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < frm.size(); i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ frm[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return ~c;
    endfunction

    task automatic buildFrame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et,
                              input int payLen, input logic [7:0] seed, input int flipAt);
        logic [31:0] fcs;
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(src[47-8*i -: 8]);
        frm.push_back(et[15:8]);
        frm.push_back(et[7:0]);
        for (int k = 0; k < payLen; k++) frm.push_back(seed + k[7:0]);
        fcs = fcsOf();
        frm.push_back(fcs[7:0]);
        frm.push_back(fcs[15:8]);
        frm.push_back(fcs[23:16]);
        frm.push_back(fcs[31:24]);
        if (flipAt >= 0) frm[14+flipAt] = frm[14+flipAt] ^ 8'h01;
        txBytes.delete();
        repeat (7) txBytes.push_back(8'h55);
        txBytes.push_back(8'hD5);
        foreach (frm[i]) txBytes.push_back(frm[i]);
    endtask

    task automatic expectPayload(input int count, input bit withLast);
        pay_t p;
        for (int k = 0; k < count; k++) begin
            p.data = frm[14+k];
            p.last = withLast && (k == count - 1);
            payQ.push_back(p);
        end
    endtask

    task automatic expectHeader(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et);
        hdr_t h;
        h.dst   = dst;
        h.src   = src;
        h.etype = et;
        hdrQ.push_back(h);
    endtask

    task automatic applyStimulus(input int gap, input int giantAt, input int abortAt);
        for (int i = 0; i < txBytes.size(); i++) begin
            @(posedge clock);
            #1;
            if (i == giantAt - 1) checkOutput("giant_before_limit", 64'(bus.errGiant), 64'd0);
            if (i == giantAt)     checkOutput("giant_at_limit", 64'(bus.errGiant), 64'd1);
            bus.rxValid = 1'b1;
            bus.rxData  = txBytes[i];
            if (i == abortAt) begin
                @(negedge clock);
                #1;
                resetN      = 1'b0;
                bus.rxValid = 1'b0;
                bus.rxData  = 8'h00;
                return;
            end
        end
        @(posedge clock);
        #1;
        bus.rxValid = 1'b0;
        bus.rxData  = 8'h00;
        if (gap > 1) repeat (gap - 1) @(posedge clock);
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while ((hdrQ.size() + payQ.size() + statQ.size()) != 0 && n < 100) begin
            @(posedge clock);
            n++;
        end
        checkOutput(name, 64'(hdrQ.size() + payQ.size() + statQ.size()), 64'd0);
        hdrQ.delete();
        payQ.delete();
        statQ.delete();
        repeat (2) @(posedge clock);
    endtask

    always @(negedge clock) begin
        if (resetN) begin
            if (bus.hdrValid) begin
                if (hdrQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_hdr: got hdr_valid=1, required none");
                end else begin
                    monHdr = hdrQ.pop_front();
                    checkOutput("dest_mac", 64'(bus.destMac), 64'(monHdr.dst));
                    checkOutput("src_mac", 64'(bus.srcMac), 64'(monHdr.src));
                    checkOutput("ethertype", 64'(bus.etherType), 64'(monHdr.etype));
                end
            end
            if (bus.payloadValid) begin
                if (payQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_payload: got data=0x%0h last=%0b, required none",
                             bus.payloadData, bus.payloadLast);
                end else begin
                    monPay = payQ.pop_front();
                    checkOutput("payload_data_last", 64'({bus.payloadData, bus.payloadLast}), 64'(monPay));
                end
            end
            if (bus.frameDone) begin
                if (statQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_frame_done: got frame_done=1, required none");
                end else begin
                    monStat = statQ.pop_front();
                    checkOutput("crc_valid", 64'(bus.crcValid), 64'(monStat.crcOk));
                    checkOutput("err_runt", 64'(bus.errRunt), 64'(monStat.runt));
                    checkOutput("err_giant", 64'(bus.errGiant), 64'(monStat.giant));
                    checkOutput("err_align", 64'(bus.errAlign), 64'(monStat.align));
                    checkOutput("frame_len", 64'(bus.frameLen), 64'(monStat.len));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        resetN      = 1'b0;
        bus.rxValid = 1'b0;
        bus.rxData  = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst_hdr_valid", 64'(bus.hdrValid), 64'd0);
        checkOutput("rst_payload_valid", 64'(bus.payloadValid), 64'd0);
        checkOutput("rst_payload_last", 64'(bus.payloadLast), 64'd0);
        checkOutput("rst_frame_done", 64'(bus.frameDone), 64'd0);
        checkOutput("rst_crc_valid", 64'(bus.crcValid), 64'd0);
        checkOutput("rst_err_runt", 64'(bus.errRunt), 64'd0);
        checkOutput("rst_err_giant", 64'(bus.errGiant), 64'd0);
        checkOutput("rst_err_align", 64'(bus.errAlign), 64'd0);
        checkOutput("rst_frame_len", 64'(bus.frameLen), 64'd0);
        checkOutput("rst_dest_mac", 64'(bus.destMac), 64'd0);
        checkOutput("rst_src_mac", 64'(bus.srcMac), 64'd0);
        checkOutput("rst_ethertype", 64'(bus.etherType), 64'd0);
        resetN = 1'b1;
        repeat (2) @(posedge clock);

        $display("[TB] good 64-byte frame");
        buildFrame(48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455, 16'h0800, 46, 8'h00, -1);
        expectHeader(48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455, 16'h0800);
        expectPayload(46, 1'b1);
        statQ.push_back(mkStat(1'b1, 1'b0, 1'b0, 1'b0, 16'd64));
        applyStimulus(3, -1, -1);
        waitDrain("drain_good");

        $display("[TB] payload bit flipped");
        buildFrame(48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455, 16'h0800, 46, 8'h00, 10);
        expectHeader(48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455, 16'h0800);
        expectPayload(46, 1'b1);
        statQ.push_back(mkStat(1'b0, 1'b0, 1'b0, 1'b0, 16'd64));
        applyStimulus(3, -1, -1);
        waitDrain("drain_flip");

        $display("[TB] 40-byte runt with valid FCS");
        buildFrame(48'h0200_0000_0001, 48'h0011_2233_4455, 16'h0806, 22, 8'h80, -1);
        expectHeader(48'h0200_0000_0001, 48'h0011_2233_4455, 16'h0806);
        expectPayload(22, 1'b1);
        statQ.push_back(mkStat(1'b1, 1'b1, 1'b0, 1'b0, 16'd40));
        applyStimulus(3, -1, -1);
        waitDrain("drain_runt");

        $display("[TB] 1530-byte giant");
        buildFrame(48'h0200_0000_0002, 48'h0011_2233_4455, 16'h0800, 1512, 8'h00, -1);
        expectHeader(48'h0200_0000_0002, 48'h0011_2233_4455, 16'h0800);
        expectPayload(1500, 1'b1);
        statQ.push_back(mkStat(1'b1, 1'b0, 1'b1, 1'b0, 16'd1530));
        applyStimulus(3, 8 + 1519, -1);
        waitDrain("drain_giant");

        $display("[TB] bad preamble 55 55 AB");
        txBytes = '{8'h55, 8'h55, 8'hAB, 8'h11, 8'h22, 8'h33};
        statQ.push_back(mkStat(1'b0, 1'b1, 1'b0, 1'b1, 16'd0));
        applyStimulus(3, -1, -1);
        waitDrain("drain_align");

        $display("[TB] reset during payload byte 20");
        buildFrame(48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455, 16'h0800, 46, 8'h00, -1);
        expectHeader(48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455, 16'h0800);
        expectPayload(15, 1'b0);
        applyStimulus(0, -1, 8 + 14 + 20);
        repeat (2) @(posedge clock);
        #1;
        checkOutput("abort_frame_len", 64'(bus.frameLen), 64'd0);
        checkOutput("abort_payload_valid", 64'(bus.payloadValid), 64'd0);
        checkOutput("abort_scoreboard", 64'(hdrQ.size() + payQ.size() + statQ.size()), 64'd0);
        resetN = 1'b1;
        repeat (2) @(posedge clock);
        expectHeader(48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455, 16'h0800);
        expectPayload(46, 1'b1);
        statQ.push_back(mkStat(1'b1, 1'b0, 1'b0, 1'b0, 16'd64));
        applyStimulus(3, -1, -1);
        waitDrain("drain_after_reset");

        $display("[TB] back-to-back frames, one idle cycle");
        buildFrame(48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455, 16'h0800, 46, 8'h00, -1);
        expectHeader(48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455, 16'h0800);
        expectPayload(46, 1'b1);
        statQ.push_back(mkStat(1'b1, 1'b0, 1'b0, 1'b0, 16'd64));
        applyStimulus(1, -1, -1);
        buildFrame(48'h0200_0000_0001, 48'h00AA_BBCC_DDEE, 16'h88B5, 50, 8'h40, -1);
        expectHeader(48'h0200_0000_0001, 48'h00AA_BBCC_DDEE, 16'h88B5);
        expectPayload(50, 1'b1);
        statQ.push_back(mkStat(1'b1, 1'b0, 1'b0, 1'b0, 16'd68));
        applyStimulus(3, -1, -1);
        waitDrain("drain_back_to_back");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
